ar_fifo_unpacker: RTL and testbench
===================================

AR_FIFO_UNPACKER -- requirements
Module: ar_fifo_unpacker

Interface
REQ-001 Parameter: iwidth, default 128, width of each wide input word in bits.
REQ-002 Parameter: l2ratio, default 2, log2 of the number of narrow lanes per wide word; ratio = 2**l2ratio.
REQ-003 Derived: owidth = iwidth/ratio; iwidth SHALL be an exact multiple of ratio.
REQ-004 CLK  input  1  clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 CLR  input  1  synchronous clear; same effect as reset.
REQ-007 I_EMPTY_N  input  1  upstream FIFO holds a word.
REQ-008 I_D  input  iwidth  upstream FIFO head word, valid when I_EMPTY_N=1.
REQ-009 I_NL  input  l2ratio  number of valid lanes in I_D minus one (0 = 1 lane, ratio-1 = all lanes).
REQ-010 I_DEQ  output  1  dequeue strobe to upstream FIFO; combinational.
REQ-011 O_VALID  output  1  O_DATA holds a lane.
REQ-012 O_READY  input  1  downstream accepts the lane this cycle.
REQ-013 O_DATA  output  owidth  current lane.
REQ-014 O_FIRST  output  1  current lane is lane 0 of its wide word.
REQ-015 O_LAST  output  1  current lane is the final valid lane (index I_NL captured) of its wide word.

Function
REQ-016 Internal state: holding register hreg (iwidth), captured lane count hnl (l2ratio), lane index lane (l2ratio), flag hvalid.
REQ-017 Two states: IDLE (hvalid=0) and BUSY (hvalid=1).
REQ-018 Lane transfer occurs when O_VALID && O_READY.
REQ-019 lastx = transfer && (lane == hnl).
REQ-020 I_DEQ = I_EMPTY_N && (!hvalid || lastx); never asserted while I_EMPTY_N=0.
REQ-021 On I_DEQ: hreg <= I_D, hnl <= I_NL, lane <= 0, hvalid <= 1 (IDLE->BUSY or BUSY->BUSY with no bubble).
REQ-022 On lastx without I_DEQ: hvalid <= 0 (BUSY->IDLE).
REQ-023 On transfer with lane != hnl: lane <= lane + 1; hreg, hnl unchanged.
REQ-024 O_VALID = hvalid; O_FIRST = hvalid && lane==0; O_LAST = hvalid && lane==hnl.
REQ-025 O_DATA = hreg bits [(k+1)*owidth-1 : k*owidth], k defined by REQ-038; O_DATA SHALL hold stable while O_VALID && !O_READY.
REQ-026 Latency: word dequeued in cycle N presents its first lane in cycle N+1.
REQ-027 Throughput: one lane per cycle sustained across word boundaries when I_EMPTY_N and O_READY held high.
REQ-028 I_NL=0: single-lane word; O_FIRST and O_LAST both high on that lane.
REQ-029 Lanes above hnl SHALL never be presented.
REQ-030 lane SHALL never exceed hnl; no wrap-around of lane within a word.

Reset
REQ-031 On RST_N=0 or CLR=1 at a rising edge: hvalid <= 0, lane <= 0, hnl <= 0; hreg not reset.
REQ-032 After reset: O_VALID=0, O_FIRST=0, O_LAST=0, I_DEQ = I_EMPTY_N.
REQ-033 Reset or CLR mid-word discards remaining lanes; no partial word resumes.
REQ-034 During reset or CLR the block SHALL still drive I_DEQ per REQ-020 from pre-reset state; I_D captured in that cycle is discarded.

Configuration
REQ-035 Macro AR_UNPACK_MSB_FIRST_EN selects lane order.
REQ-036 Defined: lane index i maps to slice k = ratio-1-i (most-significant lane first).
REQ-037 Undefined (default): lane index i maps to slice k = i (least-significant lane first).
REQ-038 k in REQ-025 is the slice given by REQ-036/REQ-037; handshake and timing are identical in both builds.

Verification
REQ-039 Reset, then I_EMPTY_N=1, I_D=0x33332222_11110000_... (iwidth=128, l2ratio=2), I_NL=3, O_READY=1 -> I_DEQ cycle 0; lanes 0..3 presented cycles 1..4; O_FIRST cycle 1, O_LAST cycle 4; order per macro.
REQ-040 Back-to-back full words, I_EMPTY_N and O_READY high -> I_DEQ pulses every 4th cycle coincident with O_LAST; O_VALID continuous, no bubble.
REQ-041 I_NL=1 then I_NL=0 words -> 2 lanes then 1 lane; second word's single lane has O_FIRST=O_LAST=1.
REQ-042 O_READY low 3 cycles on lane 2 -> O_DATA, O_FIRST, O_LAST, lane stable; I_DEQ=0 throughout; resume on O_READY=1.
REQ-043 CLR pulsed on lane 1 of a 4-lane word -> next cycle O_VALID=0; following word starts at lane 0 with O_FIRST=1.
REQ-044 I_EMPTY_N=0 after last lane accepted -> O_VALID=0 next cycle, I_DEQ=0 until I_EMPTY_N returns.

Source files
------------

// File: rtl/ar_fifo_unpacker_if.sv
// Handshake bundle between an upstream wide-word FIFO, the unpacker, and the narrow-lane consumer.
// The master modport is the unpacker side; slave is the environment driving the FIFO head and ready.
interface ar_fifo_unpacker_if #(
    parameter int iwidth  = 128,
    parameter int l2ratio = 2
);
    localparam int owidth = iwidth / (1 << l2ratio);

    logic               I_EMPTY_N;
    logic [iwidth-1:0]  I_D;
    logic [l2ratio-1:0] I_NL;
    logic               I_DEQ;
    logic               O_VALID;
    logic               O_READY;
    logic [owidth-1:0]  O_DATA;
    logic               O_FIRST;
    logic               O_LAST;

    modport master (
        input  I_EMPTY_N, I_D, I_NL, O_READY,
        output I_DEQ, O_VALID, O_DATA, O_FIRST, O_LAST
    );

    modport slave (
        output I_EMPTY_N, I_D, I_NL, O_READY,
        input  I_DEQ, O_VALID, O_DATA, O_FIRST, O_LAST
    );
endinterface

// File: rtl/ar_fifo_unpacker.sv
// Splits wide FIFO words into 2**l2ratio narrow lanes, one per accepted cycle, with first/last markers.
// Define AR_UNPACK_MSB_FIRST_EN to present the most-significant lane first (default: least-significant first).
module ar_fifo_unpacker #(
    parameter int iwidth  = 128,
    parameter int l2ratio = 2
) (
    input logic                CLK,
    input logic                RST_N,
    input logic                CLR,
    ar_fifo_unpacker_if.master bus
);
    localparam int ratio  = 1 << l2ratio;
    localparam int owidth = iwidth / ratio;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [iwidth-1:0]  hreg_q, hreg_d;
    logic [l2ratio-1:0] hnl_q, hnl_d;
    logic [l2ratio-1:0] lane_q, lane_d;
    logic [l2ratio-1:0] slice;
    logic [owidth-1:0]  lanes [ratio];
    logic               transfer, lastx, deq;

    assign transfer  = (state_q == BUSY) && bus.O_READY;
    assign lastx     = transfer && (lane_q == hnl_q);
    assign deq       = bus.I_EMPTY_N && ((state_q == IDLE) || lastx);
    assign bus.I_DEQ = deq;

    // A new word replaces the old one in the same cycle its last lane leaves, so there is no bubble.
    always_comb begin
        state_d = state_q;
        hreg_d  = hreg_q;
        hnl_d   = hnl_q;
        lane_d  = lane_q;
        if (deq) begin
            state_d = BUSY;
            hreg_d  = bus.I_D;
            hnl_d   = bus.I_NL;
            lane_d  = '0;
        end else if (lastx) begin
            state_d = IDLE;
        end else if (transfer) begin
            lane_d  = lane_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            state_q <= IDLE;
            hnl_q   <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            hnl_q   <= hnl_d;
            lane_q  <= lane_d;
        end
    end

    // The data holding register is only meaningful while BUSY, so it carries no reset.
    always_ff @(posedge CLK) begin
        hreg_q <= hreg_d;
    end

    for (genvar g = 0; g < ratio; g++) begin : g_lane
        assign lanes[g] = hreg_q[g*owidth +: owidth];
    end

`ifdef AR_UNPACK_MSB_FIRST_EN
    assign slice = ~lane_q;
`else
    assign slice = lane_q;
`endif

    assign bus.O_VALID = (state_q == BUSY);
    assign bus.O_FIRST = (state_q == BUSY) && (lane_q == '0);
    assign bus.O_LAST  = (state_q == BUSY) && (lane_q == hnl_q);
    assign bus.O_DATA  = lanes[slice];
endmodule

// File: tb/tb_ar_fifo_unpacker.sv
// Scoreboard bench for ar_fifo_unpacker: a modelled upstream FIFO feeds directed words, a monitor checks lanes.
// Honours AR_UNPACK_MSB_FIRST_EN for the expected lane order.
module tb_ar_fifo_unpacker;
    typedef struct {
        logic [127:0] data;
        logic [1:0]   nl;
    } upWord_t;

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
    } lane_t;

    logic CLK = 1'b0;
    logic RST_N;
    logic CLR;
    logic upHold;
    logic deqSeen = 1'b0;
    logic rstSeen = 1'b1;
    int   asserts = 0;
    int   failures = 0;
    int   lanesSeen = 0;

    upWord_t upQ[$];
    lane_t   sb[$];

    ar_fifo_unpacker_if #(.iwidth(128), .l2ratio(2)) bus();

    ar_fifo_unpacker #(.iwidth(128), .l2ratio(2)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (CLR),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] laneOf(input logic [127:0] w, input int i);
        int k;
`ifdef AR_UNPACK_MSB_FIRST_EN
        k = 3 - i;
`else
        k = i;
`endif
        return w[k*32 +: 32];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] data, input logic [1:0] nl);
        upWord_t w;
        w.data = data;
        w.nl   = nl;
        upQ.push_back(w);
    endtask

    // Called at posedge+1; checks the handshake at the following negedge and returns at the next posedge+1.
    task automatic checkCycle(input logic v, input logic f, input logic l, input logic d,
                              input bit chkData, input logic [31:0] data);
        @(negedge CLK);
        checkOutput("O_VALID", 128'(bus.O_VALID), 128'(v));
        checkOutput("O_FIRST", 128'(bus.O_FIRST), 128'(f));
        checkOutput("O_LAST",  128'(bus.O_LAST),  128'(l));
        checkOutput("I_DEQ",   128'(bus.I_DEQ),   128'(d));
        if (chkData) checkOutput("O_DATA", 128'(bus.O_DATA), 128'(data));
        @(posedge CLK);
        #1;
    endtask

    // Upstream FIFO model: pops on a sampled dequeue and records the lanes that word must produce.
    always begin
        upWord_t w;
        lane_t   e;
        @(posedge CLK);
        if (rstSeen) sb.delete();
        if (deqSeen && upQ.size() > 0) begin
            w = upQ.pop_front();
            if (!rstSeen) begin
                for (int i = 0; i <= int'(w.nl); i++) begin
                    e.data  = laneOf(w.data, i);
                    e.first = (i == 0);
                    e.last  = (i == int'(w.nl));
                    sb.push_back(e);
                end
            end
        end
        #2;
        bus.I_EMPTY_N = (upQ.size() > 0) && !upHold;
        bus.I_D       = (upQ.size() > 0) ? upQ[0].data : '0;
        bus.I_NL      = (upQ.size() > 0) ? upQ[0].nl : '0;
    end

    always @(negedge CLK) begin
        lane_t e;
        deqSeen = bus.I_DEQ;
        rstSeen = !RST_N || CLR;
        if (bus.O_VALID === 1'b1 && bus.O_READY === 1'b1) begin
            lanesSeen++;
            if (sb.size() == 0) begin
                checkOutput("unexpectedLane", 128'(bus.O_DATA), 128'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("laneData",  128'(bus.O_DATA),  128'(e.data));
                checkOutput("laneFirst", 128'(bus.O_FIRST), 128'(e.first));
                checkOutput("laneLast",  128'(bus.O_LAST),  128'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCycles;
        RST_N         = 1'b0;
        CLR           = 1'b0;
        upHold        = 1'b0;
        bus.O_READY   = 1'b1;
        bus.I_EMPTY_N = 1'b0;
        bus.I_D       = '0;
        bus.I_NL      = '0;
        repeat (2) @(posedge CLK);
        #1;

        // Word offered during reset is dequeued and thrown away.
        applyStimulus(128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 2'd3);
        checkCycle(0, 0, 0, 1, 0, '0);
        RST_N = 1'b1;
        checkCycle(0, 0, 0, 0, 0, '0);

        // Single full word, lanes in cycles 1..4.
        applyStimulus(128'h33332222_11110000_77776666_55554444, 2'd3);
        checkCycle(0, 0, 0, 1, 0, '0);
        checkCycle(1, 1, 0, 0, 1, laneOf(128'h33332222_11110000_77776666_55554444, 0));
        checkCycle(1, 0, 0, 0, 1, laneOf(128'h33332222_11110000_77776666_55554444, 1));
        checkCycle(1, 0, 0, 0, 1, laneOf(128'h33332222_11110000_77776666_55554444, 2));
        checkCycle(1, 0, 1, 0, 1, laneOf(128'h33332222_11110000_77776666_55554444, 3));
        checkCycle(0, 0, 0, 0, 0, '0);

        // Three back-to-back full words, no bubbles.
        applyStimulus(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 2'd3);
        applyStimulus(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 2'd3);
        applyStimulus(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 2'd3);
        checkCycle(0, 0, 0, 1, 0, '0);
        for (int c = 1; c <= 12; c++) begin
            checkCycle(1, (c % 4) == 1, (c % 4) == 0, ((c % 4) == 0) && (c < 12), 0, '0);
        end
        checkCycle(0, 0, 0, 0, 0, '0);

        // Two-lane word followed by a single-lane word.
        applyStimulus(128'h0_0_12345678_87654321, 2'd1);
        applyStimulus(128'h0_0_0_CAFEF00D, 2'd0);
        checkCycle(0, 0, 0, 1, 0, '0);
        checkCycle(1, 1, 0, 0, 0, '0);
        checkCycle(1, 0, 1, 1, 0, '0);
        checkCycle(1, 1, 1, 0, 1, laneOf(128'h0_0_0_CAFEF00D, 0));
        checkCycle(0, 0, 0, 0, 0, '0);

        // Downstream stall on lane 2 with another word waiting upstream.
        applyStimulus(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 2'd3);
        checkCycle(0, 0, 0, 1, 0, '0);
        checkCycle(1, 1, 0, 0, 0, '0);
        checkCycle(1, 0, 0, 0, 0, '0);
        bus.O_READY = 1'b0;
        applyStimulus(128'h0_0_0_E0E0E0E0, 2'd0);
        for (int s = 0; s < 3; s++) begin
            checkCycle(1, 0, 0, 0, 1, laneOf(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 2));
        end
        bus.O_READY = 1'b1;
        checkCycle(1, 0, 0, 0, 1, laneOf(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 2));
        checkCycle(1, 0, 1, 1, 1, laneOf(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 3));
        checkCycle(1, 1, 1, 0, 1, laneOf(128'h0_0_0_E0E0E0E0, 0));
        checkCycle(0, 0, 0, 0, 0, '0);

        // Clear on lane 1 discards the rest of the word.
        applyStimulus(128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 2'd3);
        checkCycle(0, 0, 0, 1, 0, '0);
        checkCycle(1, 1, 0, 0, 0, '0);
        applyStimulus(128'h93939393_92929292_91919191_90909090, 2'd3);
        CLR = 1'b1;
        checkCycle(1, 0, 0, 0, 1, laneOf(128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 1));
        CLR = 1'b0;
        checkCycle(0, 0, 0, 1, 0, '0);
        checkCycle(1, 1, 0, 0, 1, laneOf(128'h93939393_92929292_91919191_90909090, 0));
        checkCycle(1, 0, 0, 0, 0, '0);
        checkCycle(1, 0, 0, 0, 0, '0);
        checkCycle(1, 0, 1, 0, 0, '0);
        checkCycle(0, 0, 0, 0, 0, '0);

        // Upstream empty: nothing dequeued until a word is visible.
        upHold = 1'b1;
        applyStimulus(128'h0_82828282_81818181_80808080, 2'd2);
        checkCycle(0, 0, 0, 0, 0, '0);
        checkCycle(0, 0, 0, 0, 0, '0);
        upHold = 1'b0;
        checkCycle(0, 0, 0, 1, 0, '0);
        checkCycle(1, 1, 0, 0, 0, '0);
        checkCycle(1, 0, 0, 0, 0, '0);
        checkCycle(1, 0, 1, 0, 1, laneOf(128'h0_82828282_81818181_80808080, 2));
        checkCycle(0, 0, 0, 0, 0, '0);

        waitCycles = 0;
        while (sb.size() != 0 && waitCycles < 20) begin
            @(posedge CLK);
            waitCycles++;
        end
        checkOutput("scoreboardDrain", 128'(sb.size()), 128'd0);
        checkOutput("laneCount", 128'(lanesSeen), 128'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
